// File: rtl/alu_cmd_sequencer_if.sv
// Bundles the command, ALU and response signals of the ALU command sequencer.
// "slave" is the sequencer's view; "master" is the side that issues commands,
// models the ALU and consumes responses.
interface alu_cmd_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  // Command side
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [7:0]                    cmd_x;
  logic [7:0]                    cmd_y;
  logic [2:0]                    cmd_op;
  logic [3:0]                    cmd_tag;
  // ALU side
  logic [7:0]                    alu_x;
  logic [7:0]                    alu_y;
  logic [2:0]                    alu_op;
  logic                          alu_begin;
  logic                          alu_end;
  logic [15:0]                   alu_out;
  // Response side
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [15:0]                   rsp_data;
  logic [3:0]                    rsp_tag;
  logic [2:0]                    rsp_op;
  logic                          rsp_timeout;
  // Status
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_op, cmd_tag,
    output cmd_ready,
    output alu_x, alu_y, alu_op, alu_begin,
    input  alu_end, alu_out,
    output rsp_valid, rsp_data, rsp_tag, rsp_op, rsp_timeout,
    input  rsp_ready,
    output busy, fifo_count
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_op, cmd_tag,
    input  cmd_ready,
    input  alu_x, alu_y, alu_op, alu_begin,
    output alu_end, alu_out,
    input  rsp_valid, rsp_data, rsp_tag, rsp_op, rsp_timeout,
    output rsp_ready,
    input  busy, fifo_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue/wait/settle/respond sequencer for the multi-cycle
// 8-bit ALU, with a watchdog that turns a hung operation into a timeout response.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  alu_cmd_sequencer_if.slave  io
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] op;
    logic [3:0] tag;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_RESP
  } state_t;

  cmd_t             fifo_mem [FIFO_DEPTH];
  cmd_t             cmd_in;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  cmd_t             opnd_q, opnd_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [WD_W-1:0]  wd_inc;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic [3:0]       rsp_tag_q, rsp_tag_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             full;
  logic             push;
  logic             pop;

  assign cmd_in = '{x: io.cmd_x, y: io.cmd_y, op: io.cmd_op, tag: io.cmd_tag};
  assign full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign push   = io.cmd_valid && !full;
  // The only consumer of the FIFO is the FSM leaving IDLE.
  assign pop    = (state_q == S_IDLE) && (count_q != '0);
  assign wd_inc = wd_q + WD_W'(1);

  // FIFO pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a default
    // first, so no path leaves a signal unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy and pointers are reset, so
    // stale entries are never read and the array can map onto plain RAM cells.
    if (push) fifo_mem[wr_ptr_q] <= cmd_in;
  end

  // Sequencer next-state: pop, issue, wait with watchdog, settle, respond.
  always_comb begin
    state_d       = state_q;
    opnd_d        = opnd_q;
    wd_d          = wd_q;
    rsp_data_d    = rsp_data_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_op_d      = rsp_op_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          opnd_d  = fifo_mem[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_inc;
        // A real END always beats a watchdog expiry in the same cycle.
        if (io.alu_end) begin
          state_d = S_SETTLE;
        end else if (wd_inc == WD_W'(TIMEOUT_CYCLES)) begin
          rsp_data_d    = '0;
          rsp_tag_d     = opnd_q.tag;
          rsp_op_d      = opnd_q.op;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_SETTLE: begin
        // The ALU output latches are only trusted one cycle after END.
        rsp_data_d    = io.alu_out;
        rsp_tag_d     = opnd_q.tag;
        rsp_op_d      = opnd_q.op;
        rsp_timeout_d = 1'b0;
        state_d       = S_RESP;
      end
      S_RESP: begin
        if (io.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register for FIFO control, FSM, operands, watchdog and response.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential blocks use non-blocking '<=' so every flop samples the
    // pre-edge value of its neighbours, matching the hardware.
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      opnd_q        <= '0;
      wd_q          <= '0;
      rsp_data_q    <= '0;
      rsp_tag_q     <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      opnd_q        <= opnd_d;
      wd_q          <= wd_d;
      rsp_data_q    <= rsp_data_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_op_q      <= rsp_op_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Output decode: ALU operands only while an operation is in flight.
  always_comb begin
    io.alu_x = '0;
    io.alu_y = '0;
    io.alu_op = '0;
    if ((state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_SETTLE)) begin
      io.alu_x  = opnd_q.x;
      io.alu_y  = opnd_q.y;
      io.alu_op = opnd_q.op;
    end
    io.alu_begin   = (state_q == S_ISSUE);
    io.cmd_ready   = !full;
    io.rsp_valid   = (state_q == S_RESP);
    io.rsp_data    = rsp_data_q;
    io.rsp_tag     = rsp_tag_q;
    io.rsp_op      = rsp_op_q;
    io.rsp_timeout = rsp_timeout_q;
    io.busy        = (state_q != S_IDLE) || (count_q != '0);
    io.fifo_count  = count_q;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed command sequences, a
// transaction-level model of the expected ALU traffic and responses, and a
// handful of literal expectations.
module tb_alu_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int NEVER   = 255;

  logic clk;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;

  alu_cmd_sequencer_if #(.FIFO_DEPTH(DEPTH)) io ();

  alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-tag ALU behaviour: END delay after BEGIN (NEVER = no END) and result.
  int          delay_of [16];
  logic [15:0] val_of   [16];
  // Last response seen per tag, and order of all responses.
  logic [15:0] got_data [16];
  logic        got_to   [16];
  int          rsp_log  [$];
  int          n_begin;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] op;
    logic [3:0] tag;
    int         acc;
  } tb_cmd_t;

  // Transaction model: accepted commands wait in order; each BEGIN must carry
  // the oldest one; its response is due END-delay+2 cycles after BEGIN, or
  // TIMEOUT+1 cycles after BEGIN when END does not arrive in time.
  initial begin : monitor
    tb_cmd_t     pend [$];
    tb_cmd_t     cur;
    bit          in_flight;
    int          b_cyc, due, end_cyc, last_hs, earliest, k;
    logic [15:0] e_data;
    logic        e_to;
    in_flight = 0;
    end_cyc   = -100;
    last_hs   = -100;
    n_begin   = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend.delete();
        in_flight  = 0;
        end_cyc    = -100;
        io.alu_end = 1'b0;
        continue;
      end
      if (in_flight) begin
        if (cyc < due) begin
          check("alu_x_hold",  32'(io.alu_x),  32'(cur.x));
          check("alu_y_hold",  32'(io.alu_y),  32'(cur.y));
          check("alu_op_hold", 32'(io.alu_op), 32'(cur.op));
          check("begin_pulse", 32'(io.alu_begin), 32'(cyc == b_cyc));
          check("rsp_valid_early", 32'(io.rsp_valid), 32'd0);
        end else begin
          check("rsp_valid_due", 32'(io.rsp_valid),   32'd1);
          check("rsp_data",      32'(io.rsp_data),    32'(e_data));
          check("rsp_tag",       32'(io.rsp_tag),     32'(cur.tag));
          check("rsp_op",        32'(io.rsp_op),      32'(cur.op));
          check("rsp_timeout",   32'(io.rsp_timeout), 32'(e_to));
          check("alu_x_resp",    32'(io.alu_x),       32'd0);
          check("begin_in_resp", 32'(io.alu_begin),   32'd0);
          if (io.rsp_valid && io.rsp_ready) begin
            got_data[io.rsp_tag] = io.rsp_data;
            got_to[io.rsp_tag]   = io.rsp_timeout;
            rsp_log.push_back(int'(io.rsp_tag));
            in_flight = 0;
            last_hs   = cyc;
          end
        end
      end else begin
        check("rsp_valid_idle", 32'(io.rsp_valid), 32'd0);
        if (io.alu_begin) begin
          if (pend.size() == 0) begin
            check("begin_without_cmd", 32'(io.alu_begin), 32'd0);
          end else begin
            cur      = pend.pop_front();
            earliest = ((cur.acc > last_hs) ? cur.acc : last_hs) + 2;
            check("begin_too_early", 32'(cyc >= earliest), 32'd1);
            check("alu_x_issue",  32'(io.alu_x),  32'(cur.x));
            check("alu_y_issue",  32'(io.alu_y),  32'(cur.y));
            check("alu_op_issue", 32'(io.alu_op), 32'(cur.op));
            k     = delay_of[cur.tag];
            b_cyc = cyc;
            if (k <= TIMEOUT) begin
              due     = cyc + k + 2;
              e_data  = val_of[cur.tag];
              e_to    = 1'b0;
              end_cyc = cyc + k;
            end else begin
              due     = cyc + TIMEOUT + 1;
              e_data  = 16'h0000;
              e_to    = 1'b1;
              end_cyc = (k == NEVER) ? -100 : cyc + k;
            end
            in_flight = 1;
            n_begin++;
          end
        end else begin
          check("alu_x_idle", 32'(io.alu_x), 32'd0);
          if (pend.size() > 0 &&
              cyc > ((pend[0].acc > last_hs) ? pend[0].acc : last_hs) + 4) begin
            check("begin_stall", 32'(io.alu_begin), 32'd1);
            pend.delete();
          end
        end
      end
      if (io.cmd_valid && io.cmd_ready)
        pend.push_back('{x: io.cmd_x, y: io.cmd_y, op: io.cmd_op, tag: io.cmd_tag, acc: cyc});
      // ALU model: END for one cycle, OUT garbage during END, valid afterwards.
      if (cyc == end_cyc) begin
        io.alu_end = 1'b1;
        io.alu_out = ~val_of[cur.tag];
      end else if (cyc == end_cyc + 1) begin
        io.alu_end = 1'b0;
        io.alu_out = val_of[cur.tag];
      end else begin
        io.alu_end = 1'b0;
      end
    end
  end

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  // Offer one command until accepted; t_acc is the cycle count after the accepting edge.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op,
                      input logic [3:0] tag, output int t_acc);
    int n;
    io.cmd_valid = 1'b1;
    io.cmd_x     = x;
    io.cmd_y     = y;
    io.cmd_op    = op;
    io.cmd_tag   = tag;
    t_acc        = -1;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (io.cmd_ready) break;
    end
    if (n == 400) check("cmd_accept_timeout", 32'(io.cmd_ready), 32'd1);
    else t_acc = cyc + 1;
    @(posedge clk);
    #1;
    io.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int t, output logic [15:0] d, output logic [3:0] tg,
                          output logic to);
    int n;
    t = -1; d = '0; tg = '0; to = 1'b0;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (io.rsp_valid) break;
    end
    if (n == 300) begin
      check("rsp_wait_timeout", 32'(io.rsp_valid), 32'd1);
    end else begin
      t = cyc; d = io.rsp_data; tg = io.rsp_tag; to = io.rsp_timeout;
    end
    realign();
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 600; n++) begin
      @(negedge clk);
      if (!io.busy) break;
    end
    if (n == 600) check("idle_wait_timeout", 32'(io.busy), 32'd0);
    realign();
  endtask

  initial begin : stimulus
    int          t_acc, t_rsp, n0, base;
    logic [15:0] d;
    logic [3:0]  tg;
    logic        to;
    int          exp_order [6];
    errors = 0;
    checks = 0;
    for (int i = 0; i < 16; i++) begin
      delay_of[i] = 3;
      val_of[i]   = 16'h1000 + 16'(i) * 16'h0111;
    end
    reset        = 1'b1;
    io.cmd_valid = 1'b0;
    io.cmd_x     = '0;
    io.cmd_y     = '0;
    io.cmd_op    = '0;
    io.cmd_tag   = '0;
    io.alu_end   = 1'b0;
    io.alu_out   = '0;
    io.rsp_ready = 1'b1;
    repeat (3) realign();
    check("reset_cmd_ready",  32'(io.cmd_ready),  32'd1);
    check("reset_rsp_valid",  32'(io.rsp_valid),  32'd0);
    check("reset_alu_begin",  32'(io.alu_begin),  32'd0);
    check("reset_fifo_count", 32'(io.fifo_count), 32'd0);
    check("reset_busy",       32'(io.busy),       32'd0);
    check("reset_rsp_data",   32'(io.rsp_data),   32'd0);
    reset = 1'b0;
    repeat (2) realign();

    // 1: single command, END 5 cycles after BEGIN.
    delay_of[1] = 5;
    val_of[1]   = 16'h0010;
    send(8'h12, 8'h34, 3'd0, 4'd1, t_acc);
    wait_rsp(t_rsp, d, tg, to);
    check("t1_latency", 32'(t_rsp - t_acc), 32'd8);
    check("t1_data",    32'(d),  32'h0010);
    check("t1_tag",     32'(tg), 32'd1);
    check("t1_timeout", 32'(to), 32'd0);
    wait_idle();
    check("t1_one_begin", 32'(n_begin), 32'd1);

    // 2: five commands against a 4-deep FIFO while the first one hangs.
    base = rsp_log.size();
    delay_of[2] = 20; delay_of[3] = 3; delay_of[4] = 4;
    delay_of[5] = 2;  delay_of[6] = 1; delay_of[7] = 5;
    for (int t = 2; t <= 6; t++)
      send(8'(t * 7), 8'(t * 13), 3'(t), 4'(t), t_acc);
    check("t2_fifo_full_count", 32'(io.fifo_count), 32'd4);
    check("t2_cmd_ready_low",   32'(io.cmd_ready),  32'd0);
    io.cmd_valid = 1'b1;
    io.cmd_x = 8'h77; io.cmd_y = 8'h88; io.cmd_op = 3'd7; io.cmd_tag = 4'd7;
    repeat (3) @(negedge clk);
    check("t2_sixth_held",  32'(io.cmd_ready),  32'd0);
    check("t2_count_held",  32'(io.fifo_count), 32'd4);
    send(8'h77, 8'h88, 3'd7, 4'd7, t_acc);
    wait_idle();
    exp_order = '{2, 3, 4, 5, 6, 7};
    check("t2_rsp_count", 32'(rsp_log.size() - base), 32'd6);
    if (rsp_log.size() - base == 6)
      for (int i = 0; i < 6; i++) check("t2_rsp_order", 32'(rsp_log[base + i]), 32'(exp_order[i]));

    // 3: END never arrives, watchdog aborts; the next command still runs.
    delay_of[8] = NEVER;
    send(8'hA0, 8'h0B, 3'd3, 4'd8, t_acc);
    wait_rsp(t_rsp, d, tg, to);
    check("t3_latency", 32'(t_rsp - t_acc), 32'(TIMEOUT + 2));
    check("t3_data",    32'(d),  32'd0);
    check("t3_timeout", 32'(to), 32'd1);
    delay_of[9] = 2;
    send(8'h01, 8'h02, 3'd1, 4'd9, t_acc);
    wait_rsp(t_rsp, d, tg, to);
    check("t3_next_data",    32'(d),  32'(val_of[9]));
    check("t3_next_timeout", 32'(to), 32'd0);
    wait_idle();

    // 4: response held off for 10 cycles with another command queued.
    io.rsp_ready = 1'b0;
    delay_of[10] = 3; delay_of[11] = 2;
    send(8'h5A, 8'hA5, 3'd2, 4'd10, t_acc);
    send(8'h3C, 8'hC3, 3'd6, 4'd11, t_acc);
    wait_rsp(t_rsp, d, tg, to);
    n0 = n_begin;
    repeat (10) @(negedge clk);
    check("t4_rsp_valid_held", 32'(io.rsp_valid),  32'd1);
    check("t4_tag_held",       32'(io.rsp_tag),    32'd10);
    check("t4_data_held",      32'(io.rsp_data),   32'(val_of[10]));
    check("t4_queued",         32'(io.fifo_count), 32'd1);
    check("t4_no_new_begin",   32'(n_begin),       32'(n0));
    realign();
    io.rsp_ready = 1'b1;
    wait_idle();
    check("t4_second_data", 32'(got_data[11]), 32'(val_of[11]));

    // 5: asynchronous reset mid-WAIT with two commands queued.
    delay_of[12] = NEVER;
    send(8'h11, 8'h22, 3'd4, 4'd12, t_acc);
    send(8'h33, 8'h44, 3'd5, 4'd13, t_acc);
    send(8'h55, 8'h66, 3'd6, 4'd14, t_acc);
    repeat (5) @(posedge clk);
    #1;
    check("t5_queued_before", 32'(io.fifo_count), 32'd2);
    check("t5_busy_before",   32'(io.busy),       32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_count_cleared", 32'(io.fifo_count), 32'd0);
    check("t5_rsp_valid_low", 32'(io.rsp_valid),  32'd0);
    check("t5_cmd_ready",     32'(io.cmd_ready),  32'd1);
    check("t5_begin_low",     32'(io.alu_begin),  32'd0);
    @(negedge clk);
    realign();
    reset = 1'b0;
    n0 = n_begin;
    repeat (80) realign();
    check("t5_no_begin_after", 32'(n_begin),      32'(n0));
    check("t5_no_rsp_after",   32'(io.rsp_valid), 32'd0);
    delay_of[15] = 1;
    send(8'hF0, 8'h0F, 3'd0, 4'd15, t_acc);
    wait_rsp(t_rsp, d, tg, to);
    check("t5_recover_latency", 32'(t_rsp - t_acc), 32'd4);
    check("t5_recover_data",    32'(d), 32'(val_of[15]));
    wait_idle();

    // 6: END exactly on watchdog expiry wins; one cycle later it is too late.
    delay_of[0] = TIMEOUT;     val_of[0] = 16'hBEEF;
    delay_of[1] = TIMEOUT + 1; val_of[1] = 16'hCAFE;
    send(8'h99, 8'h66, 3'd2, 4'd0, t_acc);
    send(8'h98, 8'h67, 3'd3, 4'd1, t_acc);
    wait_idle();
    check("t6_coincident_data",    32'(got_data[0]), 32'hBEEF);
    check("t6_coincident_timeout", 32'(got_to[0]),   32'd0);
    check("t6_late_data",          32'(got_data[1]), 32'd0);
    check("t6_late_timeout",       32'(got_to[1]),   32'd1);
    check("t3_logged_timeout",     32'(got_to[8]),   32'd1);

    repeat (3) realign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
